// File: rtl/wb_commit_unit_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_unit_pkg
// Shared definitions for the writeback commit slice:
//   WORD_LEN      - datapath width (matches `WORD_LEN in defines.v)
//   REG_ADDR_LEN  - register-file address width (matches `REG_FILE_ADDR_LEN)
//   wb_state_t    - commit FSM encoding (WB_IDLE, WB_MUL_HI)
//   wb_select     - writeback data priority mux for a single-destination op
// -----------------------------------------------------------------------------
package wb_commit_unit_pkg;

   localparam int WORD_LEN     = 32;
   localparam int REG_ADDR_LEN = 5;

   typedef enum logic {
      WB_IDLE   = 1'b0,
      WB_MUL_HI = 1'b1
   } wb_state_t;

   // Multiply low word wins over load data, which wins over the compare flag.
   // A compare result is the sign bit of the ALU subtraction, zero-extended.
   function automatic logic [WORD_LEN-1:0] wb_select(
      input logic                mul_en,
      input logic                mem_r_en,
      input logic                comp_en,
      input logic [WORD_LEN-1:0] alu_res,
      input logic [WORD_LEN-1:0] mem_val
   );
      if (mul_en)
         return alu_res;
      else if (mem_r_en)
         return mem_val;
      else if (comp_en)
         return {{(WORD_LEN-1){1'b0}}, alu_res[WORD_LEN-1]};
      else
         return alu_res;
   endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// -----------------------------------------------------------------------------
// wb_commit_if
// Bundles the MEM/WB register outputs consumed by the commit unit together with
// everything the unit drives (register-file write port, HI/LO, stall, bypass).
//   master - MEM/WB side / surrounding pipeline: drives *_in, observes results
//   slave  - wb_commit_unit: consumes *_in, drives rf_*, hi_q/lo_q, stall, fwd_*
// -----------------------------------------------------------------------------
interface wb_commit_if;
   import wb_commit_unit_pkg::*;

   // MEM/WB register outputs
   logic                    wb_en_in;
   logic                    mem_r_en_in;
   logic                    mul_en_in;
   logic                    comp_en_in;
   logic [REG_ADDR_LEN-1:0] dest_in;
   logic [WORD_LEN-1:0]     alu_res_in;
   logic [WORD_LEN-1:0]     mem_read_val_in;
   logic [WORD_LEN-1:0]     high_in;

   // Register-file write port and architectural state
   logic                    rf_we;
   logic [REG_ADDR_LEN-1:0] rf_waddr;
   logic [WORD_LEN-1:0]     rf_wdata;
   logic [WORD_LEN-1:0]     hi_q;
   logic [WORD_LEN-1:0]     lo_q;
   logic                    stall;

   // Registered bypass to the forwarding unit
   logic                    fwd_valid;
   logic [REG_ADDR_LEN-1:0] fwd_dest;
   logic [WORD_LEN-1:0]     fwd_data;

   modport master (
      output wb_en_in, mem_r_en_in, mul_en_in, comp_en_in,
             dest_in, alu_res_in, mem_read_val_in, high_in,
      input  rf_we, rf_waddr, rf_wdata, hi_q, lo_q, stall,
             fwd_valid, fwd_dest, fwd_data
   );

   modport slave (
      input  wb_en_in, mem_r_en_in, mul_en_in, comp_en_in,
             dest_in, alu_res_in, mem_read_val_in, high_in,
      output rf_we, rf_waddr, rf_wdata, hi_q, lo_q, stall,
             fwd_valid, fwd_dest, fwd_data
   );

endinterface

// File: rtl/wb_commit_unit_hilo_reg.sv
// -----------------------------------------------------------------------------
// wb_hilo_reg
// Architectural HI/LO register pair, loaded together when a multiply commits.
//   clk, rst      - clock, synchronous active-high reset (clears both to 0)
//   load          - capture hi_d/lo_d on this edge
//   hi_d, lo_d    - next HI / LO values
//   hi_q, lo_q    - current HI / LO values
// -----------------------------------------------------------------------------
module wb_hilo_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] hi_d,
   input  logic [WIDTH-1:0] lo_d,
   output logic [WIDTH-1:0] hi_q,
   output logic [WIDTH-1:0] lo_q
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its inputs from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (load) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

endmodule

// File: rtl/wb_commit_unit.sv
// -----------------------------------------------------------------------------
// wb_commit_unit
// Writeback-side consumer of the MEM/WB register. Selects the writeback value,
// drives the single register-file write port, keeps HI/LO, and splits a
// multiply (two destinations) over two cycles, stalling the pipe for the extra
// one.
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - wb_commit_if.slave: MEM/WB inputs, rf write port, hi_q/lo_q,
//          stall to the hazard unit, fwd_* registered bypass
// Build option: define WB_FWD_EN to register each committed write onto fwd_*
// one cycle later; otherwise fwd_* are tied to 0.
// -----------------------------------------------------------------------------
module wb_commit_unit
   import wb_commit_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   wb_commit_if.slave   bus
);

   wb_state_t               state, state_nxt;
   logic [WORD_LEN-1:0]     pend_data;
   logic [REG_ADDR_LEN-1:0] pend_dest;

   logic                    mul_accept;
   logic                    rf_we;
   logic [REG_ADDR_LEN-1:0] rf_waddr;
   logic [WORD_LEN-1:0]     rf_wdata;
   logic                    stall;

   // State register and the pending high-word write of an accepted multiply.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WB_IDLE;
         pend_data <= '0;
         pend_dest <= '0;
      end else begin
         state <= state_nxt;
         if (mul_accept) begin
            pend_data <= bus.high_in;
            // High word goes to the next register up; r31 wraps to r0, whose
            // write is then suppressed.
            pend_dest <= bus.dest_in + REG_ADDR_LEN'(1);
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      mul_accept = 1'b0;
      rf_we      = 1'b0;
      rf_waddr   = '0;
      rf_wdata   = '0;
      stall      = 1'b0;

      if (!rst) begin
         unique case (state)
            WB_IDLE: begin
               rf_we    = bus.wb_en_in && (bus.dest_in != '0);
               rf_waddr = bus.dest_in;
               rf_wdata = wb_select(bus.mul_en_in, bus.mem_r_en_in,
                                    bus.comp_en_in, bus.alu_res_in,
                                    bus.mem_read_val_in);
               if (bus.wb_en_in && bus.mul_en_in) begin
                  mul_accept = 1'b1;
                  stall      = 1'b1;
                  state_nxt  = WB_MUL_HI;
               end
            end
            WB_MUL_HI: begin
               // Inputs are a frozen copy of the multiply; only the captured
               // high word is committed here.
               rf_we     = (pend_dest != '0);
               rf_waddr  = pend_dest;
               rf_wdata  = pend_data;
               state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
         endcase
      end
   end

   assign bus.rf_we    = rf_we;
   assign bus.rf_waddr = rf_waddr;
   assign bus.rf_wdata = rf_wdata;
   assign bus.stall    = stall;

   wb_hilo_reg #(
      .WIDTH (WORD_LEN)
   ) u_hilo (
      .clk  (clk),
      .rst  (rst),
      .load (mul_accept),
      .hi_d (bus.high_in),
      .lo_d (bus.alu_res_in),
      .hi_q (bus.hi_q),
      .lo_q (bus.lo_q)
   );

`ifdef WB_FWD_EN
   logic                    fwd_valid_q;
   logic [REG_ADDR_LEN-1:0] fwd_dest_q;
   logic [WORD_LEN-1:0]     fwd_data_q;

   // Replays the last committed write for a register file that cannot bypass
   // a same-cycle read-during-write; dest/data hold when nothing is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_valid_q <= 1'b0;
         fwd_dest_q  <= '0;
         fwd_data_q  <= '0;
      end else begin
         fwd_valid_q <= rf_we;
         if (rf_we) begin
            fwd_dest_q <= rf_waddr;
            fwd_data_q <= rf_wdata;
         end
      end
   end

   assign bus.fwd_valid = fwd_valid_q;
   assign bus.fwd_dest  = fwd_dest_q;
   assign bus.fwd_data  = fwd_data_q;
`else
   assign bus.fwd_valid = 1'b0;
   assign bus.fwd_dest  = '0;
   assign bus.fwd_data  = '0;
`endif

endmodule
